cpu_ctrl_mw: RTL

//  Parametrised multi-cycle controller for the simple RISC CPU, successor to the lab controller.

---
 rtl/cpu_ctrl_mw.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_ctrl_mw.sv
`default_nettype none
// =============================================================================
// Module   : cpu_ctrl_mw
// Purpose  : Multi-cycle Moore controller for the simple RISC CPU with memory
//            wait states, wait timeout, conditional branches and a sticky error.
//            Optional macro CPU_CTRL_RETIRE_CNT_EN adds the retired[15:0] count.
// Revision : 1.0  initial release
// =============================================================================
module cpu_ctrl_mw #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  opcode,
    input  logic [1:0]  op,
    input  logic [2:0]  cond,
    input  logic        N,
    input  logic        V,
    input  logic        Z,
    input  logic        mem_ready,
    output logic [1:0]  nsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic        write,
    output logic [1:0]  vsel,
    output logic        load_pc,
    output logic        reset_pc,
    output logic        pc_sel,
    output logic        load_ir,
    output logic        load_addr,
    output logic        addr_sel,
    output logic [1:0]  mem_cmd,
    output logic        halted,
    output logic        error
`ifdef CPU_CTRL_RETIRE_CNT_EN
    ,
    output logic [15:0] retired
`endif
);

    localparam logic [1:0] NSEL_RM    = 2'b00;
    localparam logic [1:0] NSEL_RD    = 2'b01;
    localparam logic [1:0] NSEL_RN    = 2'b10;
    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_IMM   = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;
    localparam logic [1:0] MEM_NONE   = 2'b00;
    localparam logic [1:0] MEM_READ   = 2'b01;
    localparam logic [1:0] MEM_WRITE  = 2'b10;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    generate
        if (ADDR_W < 1 || CNT_W < 1 || (2 ** CNT_W) <= TIMEOUT) begin : g_bad_params
            $error("cpu_ctrl_mw: illegal ADDR_W/CNT_W/TIMEOUT combination");
        end
    endgenerate

    typedef enum logic [4:0] {
        S_RESET, S_IF1, S_IF2, S_UPD_PC, S_DECODE,
        S_GET_A, S_GET_B, S_ADD, S_CMP, S_AND, S_MVN,
        S_WRITE_REG, S_WRITE_IMM, S_PASS,
        S_ADDR, S_LD_ADDR, S_MEM_RD, S_WB_MEM,
        S_GET_RD, S_PASS_B, S_MEM_WR,
        S_BRANCH, S_HALT, S_ERROR
    } state_t;

    typedef struct packed {
        logic [1:0] nsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic       write;
        logic [1:0] vsel;
        logic       load_pc;
        logic       reset_pc;
        logic       pc_sel;
        logic       load_ir;
        logic       load_addr;
        logic       addr_sel;
        logic [1:0] mem_cmd;
        logic       halted;
        logic       error;
    } ctrl_t;

    state_t           r_state;
    state_t           w_next;
    ctrl_t            r_out;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_wait_st;
    logic             w_expired;
    logic             w_take;

    // Output decode per state; registered against the next state so the
    // outputs always match the state register.
    function automatic ctrl_t outs_of(input state_t s, input logic take);
        ctrl_t o;
        o = '0;
        case (s)
            S_RESET:     begin o.load_pc = 1'b1; o.reset_pc = 1'b1; end
            S_IF1:       begin o.mem_cmd = MEM_READ; o.addr_sel = 1'b1; end
            S_IF2:       begin o.load_ir = 1'b1; o.mem_cmd = MEM_READ; end
            S_UPD_PC:    o.load_pc = 1'b1;
            S_GET_A:     begin o.nsel = NSEL_RN; o.loada = 1'b1; end
            S_GET_B:     begin o.nsel = NSEL_RM; o.loadb = 1'b1; end
            S_ADD, S_AND, S_MVN: o.loadc = 1'b1;
            S_CMP:       o.loads = 1'b1;
            S_WRITE_REG: begin o.write = 1'b1; o.nsel = NSEL_RD; o.vsel = VSEL_C; end
            S_WRITE_IMM: begin o.write = 1'b1; o.nsel = NSEL_RN; o.vsel = VSEL_IMM; end
            S_PASS, S_PASS_B: begin o.asel = 1'b1; o.loadc = 1'b1; end
            S_ADDR:      begin o.bsel = 1'b1; o.loadc = 1'b1; end
            S_LD_ADDR:   o.load_addr = 1'b1;
            S_MEM_RD:    o.mem_cmd = MEM_READ;
            S_WB_MEM:    begin
                o.write   = 1'b1;
                o.nsel    = NSEL_RD;
                o.vsel    = VSEL_MDATA;
                o.mem_cmd = MEM_READ;
            end
            S_GET_RD:    begin o.nsel = NSEL_RD; o.loadb = 1'b1; end
            S_MEM_WR:    o.mem_cmd = MEM_WRITE;
            S_BRANCH:    begin o.load_pc = take; o.pc_sel = take; end
            S_HALT:      o.halted = 1'b1;
            S_ERROR:     o.error = 1'b1;
            default:     o = '0;
        endcase
        return o;
    endfunction

    always_comb begin
        case (cond)
            3'b000:  w_take = 1'b1;
            3'b001:  w_take = Z;
            3'b010:  w_take = ~Z;
            3'b011:  w_take = N ^ V;
            3'b100:  w_take = (N ^ V) | Z;
            default: w_take = 1'b0;
        endcase
    end

    assign w_wait_st = (r_state == S_IF1) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign w_expired = (TIMEOUT != 0) && (r_wait_cnt == TIMEOUT_CNT);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RESET:     w_next = S_IF1;
            S_IF1:       w_next = mem_ready ? S_IF2 : (w_expired ? S_ERROR : S_IF1);
            S_IF2:       w_next = S_UPD_PC;
            S_UPD_PC:    w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    3'b101:  w_next = (op == 2'b11) ? S_GET_B : S_GET_A;
                    3'b110: begin
                        if (op == 2'b10)      w_next = S_WRITE_IMM;
                        else if (op == 2'b00) w_next = S_GET_B;
                        else                  w_next = S_ERROR;
                    end
                    3'b011, 3'b100: w_next = (op == 2'b00) ? S_GET_A : S_ERROR;
                    3'b001:  w_next = (op == 2'b00) ? S_BRANCH : S_ERROR;
                    3'b111:  w_next = S_HALT;
                    default: w_next = S_ERROR;
                endcase
            end
            S_GET_A:     w_next = (opcode == 3'b101) ? S_GET_B : S_ADDR;
            S_GET_B: begin
                if (opcode == 3'b110) begin
                    w_next = S_PASS;
                end else begin
                    case (op)
                        2'b00:   w_next = S_ADD;
                        2'b01:   w_next = S_CMP;
                        2'b10:   w_next = S_AND;
                        default: w_next = S_MVN;
                    endcase
                end
            end
            S_ADD, S_AND, S_MVN, S_PASS: w_next = S_WRITE_REG;
            S_CMP, S_WRITE_REG, S_WRITE_IMM, S_WB_MEM, S_BRANCH: w_next = S_IF1;
            S_ADDR:      w_next = S_LD_ADDR;
            S_LD_ADDR:   w_next = (opcode == 3'b011) ? S_MEM_RD : S_GET_RD;
            S_MEM_RD:    w_next = mem_ready ? S_WB_MEM : (w_expired ? S_ERROR : S_MEM_RD);
            S_GET_RD:    w_next = S_PASS_B;
            S_PASS_B:    w_next = S_MEM_WR;
            S_MEM_WR:    w_next = mem_ready ? S_IF1 : (w_expired ? S_ERROR : S_MEM_WR);
            S_HALT:      w_next = S_HALT;
            S_ERROR:     w_next = S_ERROR;
            default:     w_next = S_ERROR;
        endcase
    end

    // Any state change clears the count, which covers entry into a wait state.
    always_comb begin
        if (w_next != r_state)
            w_cnt_next = '0;
        else if (w_wait_st && !mem_ready)
            w_cnt_next = r_wait_cnt + CNT_W'(1);
        else
            w_cnt_next = r_wait_cnt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_RESET;
            r_wait_cnt <= '0;
            r_out      <= outs_of(S_RESET, 1'b0);
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_cnt_next;
            r_out      <= outs_of(w_next, w_take);
        end
    end

    assign {nsel, loada, loadb, loadc, loads, asel, bsel, write, vsel,
            load_pc, reset_pc, pc_sel, load_ir, load_addr, addr_sel,
            mem_cmd, halted, error} = r_out;

`ifdef CPU_CTRL_RETIRE_CNT_EN
    logic [15:0] r_retired;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_retired <= '0;
        else if (w_next == S_IF1 && r_state != S_IF1 && r_state != S_RESET)
            r_retired <= r_retired + 16'd1;
    end

    assign retired = r_retired;
`endif

endmodule
`default_nettype wire
